// File: rtl/axis_frame_gen.sv
// AXI-stream frame generator: each accepted length command becomes one frame
// whose bytes count up from zero (or whose beats carry their index when keep is disabled).
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  s_len,
    input  logic                  s_len_valid,
    output logic                  s_len_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam int                   STEP      = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 1;
    localparam logic [LEN_WIDTH-1:0] STEP_L    = LEN_WIDTH'(STEP);
    localparam logic [LEN_WIDTH-1:0] KEEP_L    = LEN_WIDTH'(KEEP_WIDTH);
    localparam logic [KEEP_WIDTH-1:0] KEEP_ONES = '1;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [LEN_WIDTH-1:0]   offset;
    logic                   beat_hs;
    logic                   last_hs;
    logic                   load;
    logic [LEN_WIDTH-1:0]   rem_next;
    logic [LEN_WIDTH-1:0]   off_next;
    logic [LEN_WIDTH-1:0]   calc_rem;
    logic [LEN_WIDTH-1:0]   calc_off;
    logic [DATA_WIDTH-1:0]  calc_data;
    logic [KEEP_WIDTH-1:0]  calc_keep;
    logic                   calc_last;

    assign beat_hs     = m_axis_tvalid & m_axis_tready;
    assign last_hs     = beat_hs & m_axis_tlast;
    assign s_len_ready = (state == IDLE) | last_hs;
    assign load        = s_len_valid & s_len_ready & (s_len != '0);
    assign rem_next    = remaining - STEP_L;
    assign off_next    = offset + STEP_L;
    assign busy        = (state == SEND);

    // The next beat is built either from a fresh command or from the advanced counters.
    assign calc_rem = load ? s_len : rem_next;
    assign calc_off = load ? '0 : off_next;

    always_comb begin
        calc_data = '0;
        calc_keep = KEEP_ONES;
        calc_last = 1'b0;
        if (KEEP_ENABLE != 0) begin
            if (calc_rem < KEEP_L)
                calc_keep = KEEP_ONES >> (KEEP_WIDTH - int'(calc_rem));
            calc_last = (calc_rem <= KEEP_L);
            for (int i = 0; i < KEEP_WIDTH; i++)
                calc_data[i*8 +: 8] = calc_keep[i] ? 8'(calc_off + LEN_WIDTH'(i)) : 8'h00;
        end else begin
            calc_last = (calc_rem == LEN_WIDTH'(1));
            calc_data = DATA_WIDTH'(calc_off);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            offset        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (load) begin
                state         <= SEND;
                remaining     <= s_len;
                offset        <= '0;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= calc_data;
                m_axis_tkeep  <= calc_keep;
                m_axis_tlast  <= calc_last;
            end else if (beat_hs) begin
                remaining <= rem_next;
                offset    <= off_next;
                // A zero-length command arriving with the last beat also lands here and is dropped.
                if (m_axis_tlast) begin
                    state         <= IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tdata  <= '0;
                    m_axis_tkeep  <= '0;
                    m_axis_tlast  <= 1'b0;
                end else begin
                    m_axis_tdata  <= calc_data;
                    m_axis_tkeep  <= calc_keep;
                    m_axis_tlast  <= calc_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen (64-bit data): frames are modelled as a byte
// stream chopped into 8-byte beats and checked by a negedge monitor.
module tb_axis_frame_gen;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_len = '0;
    logic        s_len_valid = 1'b0;
    logic        s_len_ready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy;
    logic        frame_done;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic        pending_done = 1'b0;
    logic        held_valid = 1'b0;
    logic [63:0] held_data;
    logic [7:0]  held_keep;
    logic        held_last;
    logic        rand_ready = 1'b0;
    logic        ready_force = 1'b1;

    axis_frame_gen #(.DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_len         (s_len),
        .s_len_valid   (s_len_valid),
        .s_len_ready   (s_len_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        m_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: bytes 0..len-1 carry their index mod 256, eight per beat.
    task automatic pushFrame(input int len);
        beat_t b;
        for (int base = 0; base < len; base += 8) begin
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < 8; i++) begin
                if (base + i < len) begin
                    b.keep[i]        = 1'b1;
                    b.data[i*8 +: 8] = 8'((base + i) % 256);
                end
            end
            b.last = (base + 8 >= len);
            exp_q.push_back(b);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] len);
        int  cyc = 0;
        bit  done = 0;
        s_len       = len;
        s_len_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (s_len_ready) done = 1;
            else if (++cyc > 2000) begin
                checkOutput("cmd_timeout", 64'd0, 64'd1);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        s_len_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            exp_q.delete();
            pending_done = 1'b0;
            held_valid   = 1'b0;
        end else begin
            checkOutput("frame_done", {63'd0, frame_done}, {63'd0, pending_done});
            checkOutput("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
            checkOutput("tvalid", {63'd0, m_axis_tvalid}, {63'd0, exp_q.size() != 0});
            if (held_valid) begin
                checkOutput("hold_tdata", m_axis_tdata, held_data);
                checkOutput("hold_tkeep", {56'd0, m_axis_tkeep}, {56'd0, held_keep});
                checkOutput("hold_tlast", {63'd0, m_axis_tlast}, {63'd0, held_last});
            end
            pending_done = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("beat_tdata", m_axis_tdata, b.data);
                    checkOutput("beat_tkeep", {56'd0, m_axis_tkeep}, {56'd0, b.keep});
                    checkOutput("beat_tlast", {63'd0, m_axis_tlast}, {63'd0, b.last});
                    pending_done = b.last;
                end
            end
            held_valid = m_axis_tvalid && !m_axis_tready;
            held_data  = m_axis_tdata;
            held_keep  = m_axis_tkeep;
            held_last  = m_axis_tlast;
            if (s_len_valid && s_len_ready && s_len != 0) pushFrame(int'(s_len));
        end
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        checkOutput("rst_tdata", m_axis_tdata, 64'd0);
        checkOutput("rst_tkeep", {56'd0, m_axis_tkeep}, 64'd0);
        checkOutput("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_frame_done", {63'd0, frame_done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", {63'd0, s_len_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Single full beat
        applyStimulus(16'd8);
        @(negedge clk);
        checkOutput("len8_tdata", m_axis_tdata, 64'h0706050403020100);
        checkOutput("len8_tkeep", {56'd0, m_axis_tkeep}, 64'hFF);
        checkOutput("len8_tlast", {63'd0, m_axis_tlast}, 64'd1);
        @(negedge clk);
        checkOutput("len8_done", {63'd0, frame_done}, 64'd1);
        @(negedge clk);
        checkOutput("len8_done_once", {63'd0, frame_done}, 64'd0);

        // Partial final beat
        @(posedge clk);
        #1;
        applyStimulus(16'd13);
        @(negedge clk);
        checkOutput("len13_b0_tdata", m_axis_tdata, 64'h0706050403020100);
        checkOutput("len13_b0_tlast", {63'd0, m_axis_tlast}, 64'd0);
        @(negedge clk);
        checkOutput("len13_b1_tdata", m_axis_tdata, 64'h0000000C0B0A0908);
        checkOutput("len13_b1_tkeep", {56'd0, m_axis_tkeep}, 64'h1F);
        checkOutput("len13_b1_tlast", {63'd0, m_axis_tlast}, 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Zero-length command is swallowed
        applyStimulus(16'd0);
        @(negedge clk);
        checkOutput("len0_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        @(negedge clk);
        checkOutput("len0_no_done", {63'd0, frame_done}, 64'd0);
        @(posedge clk);
        #1;

        // Back-pressure on beat 1 of a 20-byte frame
        applyStimulus(16'd20);
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
            checkOutput("stall_tdata", m_axis_tdata, 64'h0F0E0D0C0B0A0908);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("len20_last_tkeep", {56'd0, m_axis_tkeep}, 64'h0F);
        checkOutput("len20_last_tdata", m_axis_tdata, 64'h0000000013121110);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back frames: 3 bytes then a waiting 9-byte command
        applyStimulus(16'd3);
        s_len       = 16'd9;
        s_len_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_first_tkeep", {56'd0, m_axis_tkeep}, 64'h07);
        checkOutput("b2b_first_tlast", {63'd0, m_axis_tlast}, 64'd1);
        checkOutput("b2b_ready_on_last", {63'd0, s_len_ready}, 64'd1);
        @(posedge clk);
        #1;
        s_len_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_no_gap", {63'd0, m_axis_tvalid}, 64'd1);
        checkOutput("b2b_second_tkeep", {56'd0, m_axis_tkeep}, 64'hFF);
        @(negedge clk);
        checkOutput("b2b_third_tkeep", {56'd0, m_axis_tkeep}, 64'h01);
        checkOutput("b2b_third_tdata", m_axis_tdata, 64'h08);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a long frame
        applyStimulus(16'd100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        checkOutput("async_rst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("post_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(16'd8);
        @(negedge clk);
        checkOutput("post_rst_tdata", m_axis_tdata, 64'h0706050403020100);
        repeat (2) @(posedge clk);
        #1;

        // Randomised lengths and back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(16'($urandom_range(0, 40)));
            if ($urandom_range(0, 1) != 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Maximum length frame; byte pattern wraps modulo 256
        rand_ready = 1'b0;
        applyStimulus(16'hFFFF);

        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
